// File: rtl/pu_accum_seq_pkg.sv
// Shared types for the pu_accum control sequencer: FSM state encoding,
// pu_accum control-word layout and gap-timer sizing.
package pu_accum_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_GAP    = 3'd2,
        ST_READ   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    // pu_accum control word, MSB first: load, init, neg, oe
    typedef struct packed {
        logic load;
        logic init;
        logic neg;
        logic oe;
    } ctrl_t;

    localparam int GAP_CNT_W = 4;

    function automatic logic [GAP_CNT_W-1:0] gap_reload(input int gap_cycles);
        return GAP_CNT_W'(gap_cycles - 1);
    endfunction

endpackage

// File: rtl/pu_accum_seq_if.sv
// Operand stream, result stream and pu_accum control/readback signals
// of one sequencer; master is the sequencer side.
interface pu_accum_seq_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ATTR_WIDTH = 4
);
    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_data;
    logic [ATTR_WIDTH-1:0] op_attr;
    logic                  op_neg;
    logic                  op_last;

    logic                  signal_load;
    logic                  signal_init;
    logic                  signal_neg;
    logic                  signal_oe;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ATTR_WIDTH-1:0] attr_in;
    logic [DATA_WIDTH-1:0] pu_data_out;
    logic [ATTR_WIDTH-1:0] pu_attr_out;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [ATTR_WIDTH-1:0] res_attr;
    logic                  busy;

    modport master (
        input  op_valid, op_data, op_attr, op_neg, op_last, res_ready, pu_data_out, pu_attr_out,
        output op_ready, signal_load, signal_init, signal_neg, signal_oe, data_in, attr_in,
               res_valid, res_data, res_attr, busy
    );

    modport slave (
        output op_valid, op_data, op_attr, op_neg, op_last, res_ready, pu_data_out, pu_attr_out,
        input  op_ready, signal_load, signal_init, signal_neg, signal_oe, data_in, attr_in,
               res_valid, res_data, res_attr, busy
    );
endinterface

// File: rtl/pu_accum.sv
// pu_accum processing unit: accumulates signed operands on load, clears on init,
// and presents the running result and last attribute while oe is high.
module pu_accum #(
    parameter int DATA_WIDTH = 2,
    parameter int ATTR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_signal_load,
    input  logic                  i_signal_init,
    input  logic                  i_signal_neg,
    input  logic                  i_signal_oe,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [ATTR_WIDTH-1:0] i_attr_in,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic [ATTR_WIDTH-1:0] o_attr_out
);
    logic [DATA_WIDTH-1:0] r_acc;
    logic [ATTR_WIDTH-1:0] r_attr;
    logic [DATA_WIDTH-1:0] w_base;
    logic [DATA_WIDTH-1:0] w_term;

    assign w_base = i_signal_init ? '0 : r_acc;
    assign w_term = i_signal_neg ? (~i_data_in + 1'b1) : i_data_in;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_attr <= '0;
        end else if (i_signal_load) begin
            r_acc  <= w_base + w_term;
            r_attr <= i_attr_in;
        end
    end

    assign o_data_out = i_signal_oe ? r_acc  : '0;
    assign o_attr_out = i_signal_oe ? r_attr : '0;
endmodule

// File: rtl/pu_accum_seq.sv
// Control-side sequencer for one pu_accum: turns an operand job stream into
// registered PU control words, reads the result back and offers it downstream.
//   state     | meaning
//   ST_WAIT   | idle or between operands, op_ready=1
//   ST_LOAD   | load pulse for the captured operand (init on job-first)
//   ST_GAP    | GAP_CYCLES quiet cycles, all controls 0
//   ST_READ   | oe strobe, result captured at end of cycle
//   ST_RESULT | res_valid held until res_ready
module pu_accum_seq
    import pu_accum_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ATTR_WIDTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pu_accum_seq_if.master bus
);
    localparam logic [GAP_CNT_W-1:0] GAP_RELOAD = gap_reload(GAP_CYCLES);

    state_t                r_state;
    ctrl_t                 r_ctrl;
    logic                  r_first;
    logic                  r_last;
    logic [GAP_CNT_W-1:0]  r_gap_cnt;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [ATTR_WIDTH-1:0] r_attr_in;
    logic                  r_op_ready;
    logic                  r_busy;
    logic                  r_res_valid;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [ATTR_WIDTH-1:0] r_res_attr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_WAIT;
            r_ctrl      <= '0;
            r_first     <= 1'b1;
            r_last      <= 1'b0;
            r_gap_cnt   <= '0;
            r_data_in   <= '0;
            r_attr_in   <= '0;
            r_op_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_attr  <= '0;
        end else begin
            r_ctrl    <= '0;
            r_data_in <= '0;
            r_attr_in <= '0;
            case (r_state)
                ST_WAIT: begin
                    if (bus.op_valid) begin
                        // the load word is built here so it is on the PU pins in LOAD
                        r_ctrl.load <= 1'b1;
                        r_ctrl.init <= r_first;
                        r_ctrl.neg  <= bus.op_neg;
                        r_data_in   <= bus.op_data;
                        r_attr_in   <= bus.op_attr;
                        r_last      <= bus.op_last;
                        r_op_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_first   <= 1'b0;
                    r_gap_cnt <= GAP_RELOAD;
                    r_state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        if (r_last) begin
                            r_ctrl.oe <= 1'b1;
                            r_state   <= ST_READ;
                        end else begin
                            r_op_ready <= 1'b1;
                            r_state    <= ST_WAIT;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                ST_READ: begin
                    r_res_data  <= bus.pu_data_out;
                    r_res_attr  <= bus.pu_attr_out;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_first     <= 1'b1;
                        r_op_ready  <= 1'b1;
                        r_state     <= ST_WAIT;
                    end
                end
                default: begin
                    r_op_ready <= 1'b1;
                    r_state    <= ST_WAIT;
                end
            endcase
        end
    end

    assign bus.op_ready    = r_op_ready;
    assign bus.signal_load = r_ctrl.load;
    assign bus.signal_init = r_ctrl.init;
    assign bus.signal_neg  = r_ctrl.neg;
    assign bus.signal_oe   = r_ctrl.oe;
    assign bus.data_in     = r_data_in;
    assign bus.attr_in     = r_attr_in;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_attr    = r_res_attr;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_pu_accum_seq.sv
// Bench for pu_accum_seq driving a pu_accum; job results come from a plain
// arithmetic model of signed accumulation modulo 4.
module tb_pu_accum_seq;
    localparam int DW  = 2;
    localparam int AW  = 4;
    localparam int GAP = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pu_accum_seq_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) bus ();

    pu_accum_seq #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    pu_accum #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) pu (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_signal_load(bus.signal_load), .i_signal_init(bus.signal_init),
        .i_signal_neg(bus.signal_neg), .i_signal_oe(bus.signal_oe),
        .i_data_in(bus.data_in), .i_attr_in(bus.attr_in),
        .o_data_out(bus.pu_data_out), .o_attr_out(bus.pu_attr_out)
    );

    int tests = 0;
    int fails = 0;
    int to_cnt = 0;

    // monitor logs
    int cyc = 0;
    int load_cyc[$], load_data[$], load_init[$], load_neg[$];
    int oe_cyc[$], oe_attr[$];
    int res_d[$], res_a[$];
    int ctrl_viol = 0;
    int res_hi_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.signal_load) begin
            load_cyc.push_back(cyc);
            load_data.push_back(int'(bus.data_in));
            load_init.push_back(int'(bus.signal_init));
            load_neg.push_back(int'(bus.signal_neg));
        end else if (bus.signal_init || bus.signal_neg || bus.data_in != '0 || bus.attr_in != '0) begin
            ctrl_viol++;
        end
        if (bus.signal_oe) begin
            oe_cyc.push_back(cyc);
            oe_attr.push_back(int'(bus.pu_attr_out));
        end
        if (bus.res_valid) res_hi_cnt++;
    end

    always @(posedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            res_d.push_back(int'(bus.res_data));
            res_a.push_back(int'(bus.res_attr));
        end
    end

    // job under test for the reference model
    int jd[16];
    int ja[16];
    int jn[16];

    function automatic int model_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += (jn[i] != 0) ? -jd[i] : jd[i];
        return ((s % 4) + 4) % 4;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_mon();
        load_cyc.delete(); load_data.delete(); load_init.delete(); load_neg.delete();
        oe_cyc.delete(); oe_attr.delete(); res_d.delete(); res_a.delete();
        ctrl_viol = 0;
        res_hi_cnt = 0;
    endtask

    task automatic send_op(input int d, input int a, input int n, input int l, input bit drop);
        int t = 0;
        bus.op_valid = 1'b1;
        bus.op_data  = DW'(d);
        bus.op_attr  = AW'(a);
        bus.op_neg   = n[0];
        bus.op_last  = l[0];
        while (!bus.op_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.op_ready) to_cnt++;
        @(negedge clk);
        if (drop) bus.op_valid = 1'b0;
    endtask

    task automatic wait_result(output int d, output int a);
        int t = 0;
        while (!bus.res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.res_valid) to_cnt++;
        d = int'(bus.res_data);
        a = int'(bus.res_attr);
        @(negedge clk);
    endtask

    task automatic run_job(input int n, output int d, output int a);
        for (int i = 0; i < n; i++) send_op(jd[i], ja[i], jn[i], (i == n - 1) ? 1 : 0, 1'b1);
        wait_result(d, a);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.op_ready, bus.busy, bus.res_valid} !== 3'b100)
            $display("FAIL reset_handshake: got %b expected 100", {bus.op_ready, bus.busy, bus.res_valid});
        if ({bus.op_ready, bus.busy, bus.res_valid} !== 3'b100) fails++;
        tests++;
        if ({bus.signal_load, bus.signal_init, bus.signal_neg, bus.signal_oe} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.signal_load, bus.signal_init, bus.signal_neg, bus.signal_oe});
        end
        tests++;
        if ({bus.data_in, bus.attr_in, bus.res_data, bus.res_attr} !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", {bus.data_in, bus.attr_in, bus.res_data, bus.res_attr});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_job_wrap();
        int d, a;
        clear_mon();
        jd[0] = 1; ja[0] = int'($urandom_range(0, 15)); jn[0] = 0;
        jd[1] = 3; ja[1] = int'($urandom_range(0, 15)); jn[1] = 0;
        run_job(2, d, a);
        tests++;
        if (load_cyc.size() != 2) begin fails++; $display("FAIL wrap_loads: got %0d expected 2", load_cyc.size()); end
        tests++;
        if (qget(load_data, 0) != 1 || qget(load_init, 0) != 1) begin
            fails++; $display("FAIL wrap_first: data %0d init %0d expected 1 1", qget(load_data, 0), qget(load_init, 0));
        end
        tests++;
        if (qget(load_data, 1) != 3 || qget(load_init, 1) != 0) begin
            fails++; $display("FAIL wrap_second: data %0d init %0d expected 3 0", qget(load_data, 1), qget(load_init, 1));
        end
        tests++;
        if (qget(load_cyc, 1) - qget(load_cyc, 0) != 2 + GAP) begin
            fails++; $display("FAIL wrap_spacing: got %0d expected %0d", qget(load_cyc, 1) - qget(load_cyc, 0), 2 + GAP);
        end
        tests++;
        if (oe_cyc.size() != 1) begin fails++; $display("FAIL wrap_oe_count: got %0d expected 1", oe_cyc.size()); end
        tests++;
        if (d != model_sum(2) || a != ja[1]) begin
            fails++; $display("FAIL wrap_result: got %0d/%0h expected %0d/%0h", d, a, model_sum(2), ja[1]);
        end
        tests++;
        if (ctrl_viol != 0 || to_cnt != 0) begin
            fails++; $display("FAIL wrap_quiet: viol %0d timeouts %0d expected 0 0", ctrl_viol, to_cnt);
        end
        to_cnt = 0;
    endtask

    task automatic test_job_neg();
        int d, a;
        clear_mon();
        jd[0] = 3; ja[0] = 2; jn[0] = 0;
        jd[1] = 1; ja[1] = 7; jn[1] = 1;
        run_job(2, d, a);
        tests++;
        if (qget(load_neg, 0) != 0 || qget(load_neg, 1) != 1) begin
            fails++; $display("FAIL neg_flags: got %0d %0d expected 0 1", qget(load_neg, 0), qget(load_neg, 1));
        end
        tests++;
        if (d != model_sum(2)) begin fails++; $display("FAIL neg_result: got %0d expected %0d", d, model_sum(2)); end
        tests++;
        if (to_cnt != 0) begin fails++; $display("FAIL neg_timeout: got %0d expected 0", to_cnt); end
        to_cnt = 0;
    endtask

    task automatic test_single();
        int d, a;
        clear_mon();
        jd[0] = 2; ja[0] = 10; jn[0] = 0;
        run_job(1, d, a);
        tests++;
        if (load_cyc.size() != 1 || qget(load_init, 0) != 1) begin
            fails++; $display("FAIL single_load_init: loads %0d init %0d expected 1 1", load_cyc.size(), qget(load_init, 0));
        end
        tests++;
        if (qget(oe_cyc, 0) - qget(load_cyc, 0) != 1 + GAP || oe_cyc.size() != 1) begin
            fails++; $display("FAIL single_oe_delay: got %0d expected %0d", qget(oe_cyc, 0) - qget(load_cyc, 0), 1 + GAP);
        end
        tests++;
        if (d != model_sum(1)) begin fails++; $display("FAIL single_result: got %0d expected %0d", d, model_sum(1)); end
        tests++;
        if (a != ja[0] || a != qget(oe_attr, 0)) begin
            fails++; $display("FAIL single_attr: got %0h expected %0h (oe %0h)", a, ja[0], qget(oe_attr, 0));
        end
        tests++;
        if (to_cnt != 0) begin fails++; $display("FAIL single_timeout: got %0d expected 0", to_cnt); end
        to_cnt = 0;
    endtask

    task automatic test_backpressure();
        int d0, a0, d, a, nload, exp0, t;
        clear_mon();
        bus.res_ready = 1'b0;
        jd[0] = 1; ja[0] = 5; jn[0] = 0;
        exp0 = model_sum(1);
        send_op(1, 5, 0, 1, 1'b1);
        t = 0;
        while (!bus.res_valid && t < 100) begin @(negedge clk); t++; end
        if (!bus.res_valid) to_cnt++;
        d0 = int'(bus.res_data);
        a0 = int'(bus.res_attr);
        tests++;
        if (d0 != exp0 || a0 != 5) begin fails++; $display("FAIL bp_result: got %0d/%0h expected %0d/5", d0, a0, exp0); end
        bus.op_valid = 1'b1; bus.op_data = 2'd3; bus.op_attr = 4'd6; bus.op_neg = 1'b0; bus.op_last = 1'b1;
        nload = load_cyc.size();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (!bus.res_valid || int'(bus.res_data) != d0 || int'(bus.res_attr) != a0 || bus.op_ready) begin
                fails++;
                $display("FAIL bp_hold%0d: valid %b data %0d attr %0h ready %b expected 1 %0d %0h 0",
                         i, bus.res_valid, bus.res_data, bus.res_attr, bus.op_ready, d0, a0);
            end
            @(negedge clk);
        end
        tests++;
        if (load_cyc.size() != nload || !bus.busy) begin
            fails++; $display("FAIL bp_pending: loads %0d busy %b expected %0d 1", load_cyc.size(), bus.busy, nload);
        end
        bus.res_ready = 1'b1;
        jd[0] = 3; ja[0] = 6; jn[0] = 0;
        send_op(3, 6, 0, 1, 1'b1);
        wait_result(d, a);
        tests++;
        if (qget(load_init, nload) != 1 || qget(load_data, nload) != 3) begin
            fails++; $display("FAIL bp_next_init: init %0d data %0d expected 1 3", qget(load_init, nload), qget(load_data, nload));
        end
        tests++;
        if (d != model_sum(1)) begin fails++; $display("FAIL bp_next_result: got %0d expected %0d", d, model_sum(1)); end
        tests++;
        if (to_cnt != 0) begin fails++; $display("FAIL bp_timeout: got %0d expected 0", to_cnt); end
        to_cnt = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midjob();
        int d, a;
        clear_mon();
        send_op(2, 9, 0, 0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.op_ready, bus.busy, bus.res_valid, bus.signal_load, bus.signal_init, bus.signal_neg, bus.signal_oe}
            !== 7'b1000000 || {bus.data_in, bus.attr_in, bus.res_data, bus.res_attr} !== '0) begin
            fails++;
            $display("FAIL abort_outputs: got %b %h expected 1000000 0",
                     {bus.op_ready, bus.busy, bus.res_valid, bus.signal_load, bus.signal_init, bus.signal_neg,
                      bus.signal_oe}, {bus.data_in, bus.attr_in, bus.res_data, bus.res_attr});
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        tests++;
        if (oe_cyc.size() != 0) begin fails++; $display("FAIL abort_no_oe: got %0d expected 0", oe_cyc.size()); end
        clear_mon();
        jd[0] = 1; ja[0] = 3; jn[0] = 0;
        jd[1] = 1; ja[1] = 4; jn[1] = 0;
        run_job(2, d, a);
        tests++;
        if (qget(load_init, 0) != 1) begin fails++; $display("FAIL abort_next_init: got %0d expected 1", qget(load_init, 0)); end
        tests++;
        if (d != model_sum(2)) begin fails++; $display("FAIL abort_next_result: got %0d expected %0d", d, model_sum(2)); end
        tests++;
        if (to_cnt != 0) begin fails++; $display("FAIL abort_timeout: got %0d expected 0", to_cnt); end
        to_cnt = 0;
    endtask

    task automatic test_back_to_back();
        int njobs, total, t, len;
        int bd[32], ba[32], bn[32], blast[32], bfirst[32];
        int exp_res[8], exp_attr[8];
        njobs = 5;
        total = 0;
        for (int j = 0; j < njobs; j++) begin
            len = int'($urandom_range(1, 3));
            for (int k = 0; k < len; k++) begin
                jd[k] = int'($urandom_range(0, 3));
                ja[k] = int'($urandom_range(0, 15));
                jn[k] = int'($urandom_range(0, 1));
                bd[total] = jd[k]; ba[total] = ja[k]; bn[total] = jn[k];
                bfirst[total] = (k == 0) ? 1 : 0;
                blast[total] = (k == len - 1) ? 1 : 0;
                total++;
            end
            exp_res[j] = model_sum(len);
            exp_attr[j] = ja[len - 1];
        end
        clear_mon();
        bus.res_ready = 1'b1;
        for (int i = 0; i < total; i++) send_op(bd[i], ba[i], bn[i], blast[i], 1'b0);
        bus.op_valid = 1'b0;
        t = 0;
        while (res_d.size() < njobs && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        tests++;
        if (load_cyc.size() != total) begin fails++; $display("FAIL b2b_loads: got %0d expected %0d", load_cyc.size(), total); end
        for (int i = 0; i < total; i++) begin
            tests++;
            if (qget(load_data, i) != bd[i] || qget(load_init, i) != bfirst[i] || qget(load_neg, i) != bn[i]) begin
                fails++;
                $display("FAIL b2b_load%0d: data %0d init %0d neg %0d expected %0d %0d %0d", i,
                         qget(load_data, i), qget(load_init, i), qget(load_neg, i), bd[i], bfirst[i], bn[i]);
            end
        end
        for (int i = 0; i < total - 1; i++) begin
            tests++;
            if (qget(load_cyc, i + 1) - qget(load_cyc, i) != ((blast[i] != 0) ? 4 + GAP : 2 + GAP)) begin
                fails++;
                $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, qget(load_cyc, i + 1) - qget(load_cyc, i),
                         (blast[i] != 0) ? 4 + GAP : 2 + GAP);
            end
        end
        tests++;
        if (res_d.size() != njobs || oe_cyc.size() != njobs || res_hi_cnt != njobs) begin
            fails++;
            $display("FAIL b2b_counts: res %0d oe %0d valid_cycles %0d expected %0d", res_d.size(), oe_cyc.size(),
                     res_hi_cnt, njobs);
        end
        for (int j = 0; j < njobs; j++) begin
            tests++;
            if (qget(res_d, j) != exp_res[j] || qget(res_a, j) != exp_attr[j]) begin
                fails++;
                $display("FAIL b2b_result%0d: got %0d/%0h expected %0d/%0h", j, qget(res_d, j), qget(res_a, j),
                         exp_res[j], exp_attr[j]);
            end
        end
        tests++;
        if (ctrl_viol != 0 || to_cnt != 0) begin
            fails++; $display("FAIL b2b_quiet: viol %0d timeouts %0d expected 0 0", ctrl_viol, to_cnt);
        end
        to_cnt = 0;
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_data   = '0;
        bus.op_attr   = '0;
        bus.op_neg    = 1'b0;
        bus.op_last   = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_job_wrap();
        test_job_neg();
        test_single();
        test_backpressure();
        test_reset_midjob();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
